// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: FSM states and parameter limits.
package alu_pkg;

    // Legal parameter ranges for the scheduler.
    localparam int unsigned LatMin = 1;
    localparam int unsigned LatMax = 4;
    localparam int unsigned ReqMin = 2;
    localparam int unsigned ReqMax = 8;

    // Wait counter must hold any legal latency value.
    localparam int unsigned CntW = $clog2(LatMax + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first requester at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned R = 4
) (
    input  logic [R-1:0]         req,
    input  logic [$clog2(R)-1:0] ptr,
    output logic [R-1:0]         grant,
    output logic [$clog2(R)-1:0] idx
);

    localparam int unsigned IdW = $clog2(R);

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = int'(R) - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % int'(R)]) begin
                grant = '0;
                grant[(int'(ptr) + off) % int'(R)] = 1'b1;
                idx = IdW'((int'(ptr) + off) % int'(R));
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU between R requesters, one operation in flight at a time.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned M   = 4,
    parameter int unsigned R   = 4,
    parameter int unsigned LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [R-1:0]         req_valid,
    output logic [R-1:0]         req_ready,
    input  logic [R*N-1:0]       req_a,
    input  logic [R*N-1:0]       req_b,
    input  logic [R*M-1:0]       req_instr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [N-1:0]         resp_data,
    output logic [$clog2(R)-1:0] resp_id,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [M-1:0]         alu_instr,
    input  logic [N-1:0]         alu_out,
    output logic                 busy
);

    localparam int unsigned IdW = $clog2(R);

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  resp_id_q, resp_id_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    resp_data_q, resp_data_d;
    logic [N-1:0]    alu_a_q, alu_a_d;
    logic [N-1:0]    alu_b_q, alu_b_d;
    logic [M-1:0]    alu_instr_q, alu_instr_d;

    logic [R-1:0]    grant;
    logic [IdW-1:0]  grant_idx;

    rr_arbiter #(
        .R (R)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Next-state logic: accept in IDLE, count down ALU latency, hold result until taken.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_instr_d = alu_instr_q;
        req_ready   = '0;

        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    req_ready   = grant;
                    alu_a_d     = req_a[int'(grant_idx) * N +: N];
                    alu_b_d     = req_b[int'(grant_idx) * N +: N];
                    alu_instr_d = req_instr[int'(grant_idx) * M +: M];
                    resp_id_d   = grant_idx;
                    cnt_d       = CntW'(LAT);
                    state_d     = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                // Counter at 1 means the ALU output is valid on this edge.
                if (cnt_q == CntW'(1)) begin
                    resp_data_d = alu_out;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (resp_id_q == IdW'(R - 1)) ? '0 : resp_id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously to drop any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            resp_id_q   <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_instr_q <= alu_instr_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_instr  = alu_instr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: directed table, corner sequences, random run against a model.
module tb_alu_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned M    = 4;
    localparam int unsigned R    = 4;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT4 = 4;

    logic clk;
    logic rst_n;

    // Instance with LAT=1
    logic [R-1:0]   req_valid, req_ready;
    logic [R*N-1:0] req_a, req_b;
    logic [R*M-1:0] req_instr;
    logic           resp_valid, resp_ready, busy;
    logic [N-1:0]   resp_data, alu_a, alu_b, alu_out;
    logic [1:0]     resp_id;
    logic [M-1:0]   alu_instr;
    logic [N-1:0]   op_a [R];
    logic [N-1:0]   op_b [R];
    logic [M-1:0]   op_i [R];

    // Instance with LAT=4
    logic [R-1:0]   req_valid_4, req_ready_4;
    logic [R*N-1:0] req_a_4, req_b_4;
    logic [R*M-1:0] req_instr_4;
    logic           resp_valid_4, resp_ready_4, busy_4;
    logic [N-1:0]   resp_data_4, alu_a_4, alu_b_4, alu_out_4;
    logic [1:0]     resp_id_4;
    logic [M-1:0]   alu_instr_4;
    logic [N-1:0]   op_a4 [R];
    logic [N-1:0]   op_b4 [R];
    logic [M-1:0]   op_i4 [R];

    int n_vec;
    int n_err;

    typedef struct {
        logic [R-1:0] valid;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [M-1:0] instr;
        int           id;
        logic [N-1:0] data;
    } vec_t;

    vec_t tbl [8];

    alu_scheduler #(.N(N), .M(M), .R(R), .LAT(LAT1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_instr  (req_instr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_instr  (alu_instr),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    alu_scheduler #(.N(N), .M(M), .R(R), .LAT(LAT4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_4),
        .req_ready  (req_ready_4),
        .req_a      (req_a_4),
        .req_b      (req_b_4),
        .req_instr  (req_instr_4),
        .resp_valid (resp_valid_4),
        .resp_ready (resp_ready_4),
        .resp_data  (resp_data_4),
        .resp_id    (resp_id_4),
        .alu_a      (alu_a_4),
        .alu_b      (alu_b_4),
        .alu_instr  (alu_instr_4),
        .alu_out    (alu_out_4),
        .busy       (busy_4)
    );

    // Reference ALU: MSB picks logic unit, low bits pick the operation.
    function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [M-1:0] ins);
        logic [M-2:0] op;
        op = ins[M-2:0];
        if (ins[M-1]) begin
            case (op)
                0:       return a & b;
                1:       return a | b;
                2:       return a ^ b;
                default: return ~a;
            endcase
        end else begin
            case (op)
                0:       return a + b;
                1:       return a - b;
                2:       return a + 1'b1;
                default: return a;
            endcase
        end
    endfunction

    // Round-robin rule: first valid requester searching upward from p with wrap.
    function automatic int rr_pick(input logic [R-1:0] m, input int p);
        for (int k = 0; k < int'(R); k++) begin
            if (m[(p + k) % int'(R)]) return (p + k) % int'(R);
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] onehot(input int g);
        logic [R-1:0] o;
        o = '0;
        if (g >= 0) o[g] = 1'b1;
        return o;
    endfunction

    function automatic int oh2idx(input logic [R-1:0] o);
        for (int k = 0; k < int'(R); k++) begin
            if (o[k]) return k;
        end
        return -1;
    endfunction

    assign alu_out   = alu_f(alu_a, alu_b, alu_instr);
    assign alu_out_4 = alu_f(alu_a_4, alu_b_4, alu_instr_4);

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_instr = '0;
        for (int i = 0; i < int'(R); i++) begin
            req_a[i*N +: N]     = op_a[i];
            req_b[i*N +: N]     = op_b[i];
            req_instr[i*M +: M] = op_i[i];
        end
    end

    always_comb begin
        req_a_4 = '0;
        req_b_4 = '0;
        req_instr_4 = '0;
        for (int i = 0; i < int'(R); i++) begin
            req_a_4[i*N +: N]     = op_a4[i];
            req_b_4[i*N +: N]     = op_b4[i];
            req_instr_4[i*M +: M] = op_i4[i];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One table transaction on the LAT=1 instance, resp_ready held high.
    task automatic run_vec(input vec_t v);
        int lat;
        for (int i = 0; i < int'(R); i++) begin
            op_a[i] = v.a;
            op_b[i] = v.b;
            op_i[i] = v.instr;
        end
        req_valid  = v.valid;
        resp_ready = 1'b1;
        #1;
        check("tbl grant", req_ready, onehot(v.id));
        tick();
        req_valid = '0;
        check("tbl alu_a", alu_a, v.a);
        check("tbl alu_instr", alu_instr, v.instr);
        lat = 0;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("tbl latency", lat, LAT1);
        check("tbl resp_data", resp_data, v.data);
        check("tbl resp_id", resp_id, v.id);
        tick();
        check("tbl idle after handshake", busy, 0);
    endtask

    initial begin
        int gq[$];
        int cq[$];
        int lat;
        int cnt;
        int mptr;
        int g;
        int stall;
        logic [R-1:0] mask;
        logic [N-1:0] exp_d;
        logic rr;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        req_valid_4 = '0;
        resp_ready_4 = 1'b0;
        for (int i = 0; i < int'(R); i++) begin
            op_a[i] = '0; op_b[i] = '0; op_i[i] = '0;
            op_a4[i] = '0; op_b4[i] = '0; op_i4[i] = '0;
        end

        // valid, a, b, instr, expected id, expected data; rr_ptr starts at 0
        tbl[0] = '{4'b0100, 4'd3,  4'd5,  4'b0000, 2, 4'd8};   // add
        tbl[1] = '{4'b1010, 4'hC,  4'hA,  4'b1000, 3, 4'h8};   // AND, ptr=3
        tbl[2] = '{4'b1010, 4'hC,  4'hA,  4'b1001, 1, 4'hE};   // OR, wrap to 1
        tbl[3] = '{4'b0001, 4'd7,  4'd9,  4'b0001, 0, 4'd14};  // sub wraps
        tbl[4] = '{4'b1111, 4'd15, 4'd1,  4'b0000, 1, 4'd0};   // add overflow
        tbl[5] = '{4'b1111, 4'd5,  4'd3,  4'b1010, 2, 4'd6};   // XOR
        tbl[6] = '{4'b1111, 4'd9,  4'd0,  4'b0010, 3, 4'd10};  // inc
        tbl[7] = '{4'b1111, 4'hA,  4'd5,  4'b1011, 0, 4'h5};   // NOT a

        #1 rst_n = 1'b0;
        #2;
        check("reset busy", busy, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_data", resp_data, 0);
        check("reset resp_id", resp_id, 0);
        check("reset alu_a", alu_a, 0);
        check("reset alu_b", alu_b, 0);
        check("reset alu_instr", alu_instr, 0);
        check("reset req_ready", req_ready, 0);
        check("reset busy4", busy_4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(tbl[k]);

        // All four valid: rotating grants, one accept every LAT+2 cycles.
        do_reset();
        for (int i = 0; i < int'(R); i++) begin
            op_a[i] = N'(i); op_b[i] = 4'd1; op_i[i] = '0;
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (req_ready != '0) begin
                gq.push_back(oh2idx(req_ready));
                cq.push_back(cyc);
            end
            tick();
        end
        req_valid = '0;
        check("tput count", gq.size(), 6);
        for (int k = 0; k < gq.size(); k++) begin
            check("tput order", gq[k], k % int'(R));
            if (k > 0) check("tput spacing", cq[k] - cq[k-1], LAT1 + 2);
        end
        cnt = 0;
        while (busy && cnt < 20) begin
            tick();
            cnt++;
        end
        check("tput drain", busy, 0);

        // Backpressure: last grant was 1, so rr_ptr=2; only requester 1 valid.
        op_a[1] = 4'd2; op_b[1] = 4'd4; op_i[1] = 4'b0000;
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        #1;
        check("bp grant", req_ready, 4'b0010);
        tick();
        req_valid = '1;
        lat = 0;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            check("bp resp_valid", resp_valid, 1);
            check("bp resp_data", resp_data, 6);
            check("bp resp_id", resp_id, 1);
            check("bp req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp no accept in handshake cycle", req_ready, 0);
        tick();
        check("bp idle", busy, 0);
        check("bp next grant from ptr 2", req_ready, 4'b0100);
        req_valid  = '0;
        resp_ready = 1'b0;

        // Reset in the middle of a LAT=4 wait discards the operation.
        op_a4[2] = 4'hA; op_b4[2] = 4'd3; op_i4[2] = 4'b1001;
        req_valid_4 = 4'b0100;
        #1;
        check("rst4 grant", req_ready_4, 4'b0100);
        tick();
        req_valid_4 = '0;
        tick();
        check("rst4 busy before", busy_4, 1);
        check("rst4 alu_a before", alu_a_4, 4'hA);
        #2 rst_n = 1'b0;
        #1;
        check("rst4 busy", busy_4, 0);
        check("rst4 resp_valid", resp_valid_4, 0);
        check("rst4 alu_a", alu_a_4, 0);
        check("rst4 alu_instr", alu_instr_4, 0);
        check("rst4 resp_id", resp_id_4, 0);
        check("rst4 resp_data", resp_data_4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready_4 = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid_4 || busy_4) cnt++;
            tick();
        end
        check("rst4 no response after release", cnt, 0);
        resp_ready_4 = 1'b0;

        // Random traffic on the LAT=4 instance against the transaction model.
        mptr = 0;
        for (int t = 0; t < 50; t++) begin
            mask = R'($urandom_range(0, (1 << R) - 1));
            for (int i = 0; i < int'(R); i++) begin
                op_a4[i] = N'($urandom);
                op_b4[i] = N'($urandom);
                op_i4[i] = M'($urandom);
            end
            req_valid_4  = mask;
            resp_ready_4 = 1'b0;
            #1;
            g = rr_pick(mask, mptr);
            check("rand grant", req_ready_4, onehot(g));
            if (g < 0) begin
                tick();
                continue;
            end
            exp_d = alu_f(op_a4[g], op_b4[g], op_i4[g]);
            tick();
            lat = 0;
            while (!resp_valid_4 && lat < 12) begin
                req_valid_4 = R'($urandom);
                #1;
                check("rand no grant while waiting", req_ready_4, 0);
                tick();
                lat++;
            end
            check("rand latency", lat, LAT4);
            stall = 0;
            do begin
                rr = ($urandom_range(0, 2) == 0) || (stall >= 5);
                resp_ready_4 = rr;
                req_valid_4  = R'($urandom);
                #1;
                check("rand resp_valid", resp_valid_4, 1);
                check("rand resp_data", resp_data_4, exp_d);
                check("rand resp_id", resp_id_4, g);
                check("rand no grant in resp", req_ready_4, 0);
                tick();
                stall++;
            end while (!rr);
            mptr = (g + 1) % int'(R);
            req_valid_4  = '0;
            resp_ready_4 = 1'b0;
            check("rand idle after handshake", busy_4, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
